// File: rtl/commit_pkg.sv
// Shared types for the N-port commit unit: instruction commit classes and
// fence sequencing states.
package commit_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_STORE = 3'd1,
    CLS_CSR   = 3'd2,
    CLS_FENCE = 3'd3,
    CLS_AMO   = 3'd4
  } commit_class_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } fence_state_e;

  function automatic logic is_class(input logic [2:0] cls, input commit_class_e ref_cls);
    return (cls == ref_cls);
  endfunction

endpackage

// File: rtl/commit_unit_nport_if.sv
// Scoreboard-head view seen by the commit unit: per-port entry fields in,
// per-port retire acknowledge out.
interface commit_unit_nport_if #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned XLEN            = 64
);
  logic [NR_COMMIT_PORTS-1:0]           instr_valid_i;
  logic [NR_COMMIT_PORTS-1:0][2:0]      instr_class_i;
  logic [NR_COMMIT_PORTS-1:0]           instr_ex_valid_i;
  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] instr_ex_cause_i;
  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] instr_pc_i;
  logic [NR_COMMIT_PORTS-1:0][4:0]      instr_rd_i;
  logic [NR_COMMIT_PORTS-1:0]           instr_we_i;
  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] instr_result_i;
  logic [NR_COMMIT_PORTS-1:0]           commit_ack_o;

  modport master (
    output instr_valid_i, instr_class_i, instr_ex_valid_i, instr_ex_cause_i,
           instr_pc_i, instr_rd_i, instr_we_i, instr_result_i,
    input  commit_ack_o
  );

  modport slave (
    input  instr_valid_i, instr_class_i, instr_ex_valid_i, instr_ex_cause_i,
           instr_pc_i, instr_rd_i, instr_we_i, instr_result_i,
    output commit_ack_o
  );
endinterface

// File: rtl/commit_unit_nport_arbiter.sv
// commit_port_arbiter: combinational in-order eligibility chain across the
// commit ports, with write-port budget and same-cycle rd conflict checks.
module commit_port_arbiter
  import commit_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 2
) (
  input  logic                            commit_en_i,
  input  logic                            fence_ack_i,
  input  logic                            lsu_ready_i,
  input  logic                            no_st_pending_i,
  input  logic [NR_COMMIT_PORTS-1:0]      valid_i,
  input  logic [NR_COMMIT_PORTS-1:0][2:0] class_i,
  input  logic [NR_COMMIT_PORTS-1:0]      ex_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0] rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]      we_i,
  output logic [NR_COMMIT_PORTS-1:0]      ack_o,
  output logic [NR_COMMIT_PORTS-1:0]      we_gpr_o
);

  localparam int unsigned CNT_W = $clog2(NR_COMMIT_PORTS + 1);

  logic [CNT_W-1:0] wb_cnt_s;
  logic             chain_ok_s;
  logic             conflict_s;

  // Port 0 follows its class rule; higher ports only extend an unbroken ALU run.
  always_comb begin
    ack_o      = '0;
    we_gpr_o   = '0;
    wb_cnt_s   = '0;
    chain_ok_s = 1'b0;
    conflict_s = 1'b0;

    if (valid_i[0] && commit_en_i && ex_valid_i[0]) begin
      ack_o[0] = 1'b1;
    end else if (valid_i[0] && fence_ack_i) begin
      ack_o[0] = 1'b1;
    end else if (valid_i[0] && commit_en_i) begin
      case (class_i[0])
        CLS_ALU:   ack_o[0] = 1'b1;
        CLS_STORE: ack_o[0] = lsu_ready_i;
        CLS_CSR:   ack_o[0] = 1'b1;
        CLS_AMO:   ack_o[0] = no_st_pending_i;
        default:   ack_o[0] = 1'b0;
      endcase
    end else begin
      ack_o[0] = 1'b0;
    end

    we_gpr_o[0] = ack_o[0] & we_i[0] & (rd_i[0] != 5'd0) & ~ex_valid_i[0];
    wb_cnt_s    = CNT_W'(we_gpr_o[0]);
    chain_ok_s  = ack_o[0] & ~ex_valid_i[0] & is_class(class_i[0], CLS_ALU);

    for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
      conflict_s = 1'b0;
      for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
        if ((j < k) && we_gpr_o[j] && (rd_i[j] == rd_i[k]) && (rd_i[k] != 5'd0)) begin
          conflict_s = 1'b1;
        end else begin
          conflict_s = conflict_s;
        end
      end
      if (chain_ok_s && valid_i[k] && is_class(class_i[k], CLS_ALU) && !ex_valid_i[k] &&
          !(we_i[k] && (wb_cnt_s >= CNT_W'(NR_WB_PORTS))) && !conflict_s) begin
        ack_o[k]    = 1'b1;
        we_gpr_o[k] = we_i[k] & (rd_i[k] != 5'd0);
        wb_cnt_s    = wb_cnt_s + CNT_W'(we_gpr_o[k]);
      end else begin
        chain_ok_s  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/commit_unit_nport.sv
// Multi-port in-order commit unit with fence drain FSM.
// Optional retired-instruction counter enabled by COMMIT_UNIT_PERF_EN.
module commit_unit_nport
  import commit_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 2,
  parameter int unsigned XLEN            = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 halt_i,
  input  logic                                 flush_i,
  commit_unit_nport_if.slave                   sb,
  input  logic                                 lsu_ready_i,
  input  logic                                 no_st_pending_i,
  output logic [$clog2(NR_COMMIT_PORTS+1)-1:0] commit_cnt_o,
  output logic [NR_COMMIT_PORTS-1:0]           we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]      waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] wdata_o,
  output logic                                 commit_lsu_o,
  output logic                                 commit_csr_o,
  output logic                                 fence_o,
  output logic                                 exception_valid_o,
  output logic [XLEN-1:0]                      exception_cause_o,
  output logic [XLEN-1:0]                      exception_pc_o,
  output logic [63:0]                          instret_o
);

  localparam int unsigned CNT_W = $clog2(NR_COMMIT_PORTS + 1);

  fence_state_e               state_q, state_d;
  logic                       fence_ack_s;
  logic                       head_fence_s;
  logic                       commit_en_s;
  logic                       exc_s;
  logic [NR_COMMIT_PORTS-1:0] ack_s;
  logic [CNT_W-1:0]           cnt_s;

  assign commit_en_s  = ~rst_i & ~halt_i & (state_q == IDLE);
  assign head_fence_s = sb.instr_valid_i[0] & ~sb.instr_ex_valid_i[0] &
                        is_class(sb.instr_class_i[0], CLS_FENCE);

  // Fence state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fence sequencing; flush_i overrides a coincident fence retire.
  always_comb begin
    state_d     = state_q;
    fence_ack_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (!halt_i && head_fence_s && no_st_pending_i) begin
          fence_ack_s = 1'b1;
          state_d     = FLUSH;
        end else if (!halt_i && head_fence_s) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (!halt_i && head_fence_s && no_st_pending_i) begin
          fence_ack_s = 1'b1;
          state_d     = FLUSH;
        end else begin
          state_d = DRAIN;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      state_d     = IDLE;
      fence_ack_s = 1'b0;
    end else begin
      state_d     = state_d;
    end
  end

  commit_port_arbiter #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .NR_WB_PORTS     (NR_WB_PORTS)
  ) u_arb (
    .commit_en_i     (commit_en_s),
    .fence_ack_i     (fence_ack_s),
    .lsu_ready_i     (lsu_ready_i),
    .no_st_pending_i (no_st_pending_i),
    .valid_i         (sb.instr_valid_i),
    .class_i         (sb.instr_class_i),
    .ex_valid_i      (sb.instr_ex_valid_i),
    .rd_i            (sb.instr_rd_i),
    .we_i            (sb.instr_we_i),
    .ack_o           (ack_s),
    .we_gpr_o        (we_gpr_o)
  );

  // Population count of retired entries.
  always_comb begin
    cnt_s = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      cnt_s = cnt_s + CNT_W'(ack_s[k]);
    end
  end

  assign exc_s             = commit_en_s & sb.instr_valid_i[0] & sb.instr_ex_valid_i[0];
  assign sb.commit_ack_o   = ack_s;
  assign commit_cnt_o      = cnt_s;
  assign fence_o           = fence_ack_s;
  assign exception_valid_o = exc_s;
  assign exception_cause_o = exc_s ? sb.instr_ex_cause_i[0] : '0;
  assign exception_pc_o    = exc_s ? sb.instr_pc_i[0] : '0;
  assign commit_lsu_o      = commit_en_s & sb.instr_valid_i[0] & ~sb.instr_ex_valid_i[0] &
                             is_class(sb.instr_class_i[0], CLS_STORE);
  assign commit_csr_o      = commit_en_s & sb.instr_valid_i[0] & ~sb.instr_ex_valid_i[0] &
                             is_class(sb.instr_class_i[0], CLS_CSR);
  assign waddr_o           = rst_i ? '0 : sb.instr_rd_i;
  assign wdata_o           = rst_i ? '0 : sb.instr_result_i;

`ifdef COMMIT_UNIT_PERF_EN
  logic [63:0] instret_q, instret_d;

  // Exception-acked entries do not count as retired work.
  always_comb begin
    instret_d = instret_q + 64'(cnt_s) - 64'(exc_s);
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_o = rst_i ? 64'd0 : instret_q;
`else
  assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_commit_unit_nport.sv
// Self-checking bench for commit_unit_nport (4 commit ports, 2 write ports):
// vector table, directed multi-cycle sequences and randomized reference-model run.
module tb_commit_unit_nport;

  localparam int N  = 4;
  localparam int WB = 2;

  logic clk = 1'b0;
  logic rst, halt, flush, lsu_rdy, no_st;
  logic [2:0]  cnt_o;
  logic [3:0]  we_gpr_o;
  logic [3:0][4:0]  waddr_o;
  logic [3:0][63:0] wdata_o;
  logic commit_lsu_o, commit_csr_o, fence_o, exc_o;
  logic [63:0] cause_o, pc_o, instret_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0]  e_ack, e_we;
  logic        e_lsu, e_csr, e_fence, e_exc;
  logic [63:0] e_cause, e_pc, e_instret;
  logic        m_drain, m_flush;
  logic [63:0] m_instret;

  commit_unit_nport_if #(.NR_COMMIT_PORTS(N), .XLEN(64)) sb ();

  commit_unit_nport #(.NR_COMMIT_PORTS(N), .NR_WB_PORTS(WB), .XLEN(64)) dut (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .flush_i(flush), .sb(sb),
    .lsu_ready_i(lsu_rdy), .no_st_pending_i(no_st),
    .commit_cnt_o(cnt_o), .we_gpr_o(we_gpr_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .commit_lsu_o(commit_lsu_o), .commit_csr_o(commit_csr_o), .fence_o(fence_o),
    .exception_valid_o(exc_o), .exception_cause_o(cause_o), .exception_pc_o(pc_o),
    .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] cls;
    logic [3:0]  ex;
    logic [19:0] rd;
    logic [3:0]  we;
    logic        lsu_rdy;
    logic        no_st;
    logic        halt;
    logic [3:0]  exp_ack;
    logic [3:0]  exp_we;
  } vec_t;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] v, input logic [11:0] c, input logic [3:0] e,
                        input logic [19:0] r, input logic [3:0] w);
    sb.instr_valid_i    = v;
    sb.instr_class_i    = c;
    sb.instr_ex_valid_i = e;
    sb.instr_rd_i       = r;
    sb.instr_we_i       = w;
    for (int k = 0; k < N; k++) begin
      sb.instr_result_i[k]   = {$urandom, $urandom};
      sb.instr_pc_i[k]       = {$urandom, $urandom};
      sb.instr_ex_cause_i[k] = 64'($urandom_range(0, 15));
    end
  endtask

  function automatic logic head_is_fence();
    return sb.instr_valid_i[0] && (sb.instr_class_i[0] == 3'd3) && !sb.instr_ex_valid_i[0];
  endfunction

  // Reference: program-order retire rules evaluated port by port.
  task automatic model_eval();
    int   writes;
    logic ok, clash;
    e_ack = '0; e_we = '0; e_lsu = 0; e_csr = 0; e_fence = 0; e_exc = 0;
    e_cause = '0; e_pc = '0;
    if (!rst) begin
      if (!halt && !m_flush && head_is_fence() && no_st && !flush) begin
        e_ack[0] = 1; e_fence = 1;
      end else if (!halt && !m_drain && !m_flush && sb.instr_valid_i[0]) begin
        if (sb.instr_ex_valid_i[0]) begin
          e_ack[0] = 1; e_exc = 1;
          e_cause = sb.instr_ex_cause_i[0]; e_pc = sb.instr_pc_i[0];
        end else begin
          case (sb.instr_class_i[0])
            3'd0: e_ack[0] = 1;
            3'd1: begin e_lsu = 1; e_ack[0] = lsu_rdy; end
            3'd2: begin e_csr = 1; e_ack[0] = 1; end
            3'd4: e_ack[0] = no_st;
            default: e_ack[0] = 0;
          endcase
        end
      end
      writes = 0;
      if (e_ack[0] && !e_exc && sb.instr_we_i[0] && sb.instr_rd_i[0] != 5'd0) begin
        e_we[0] = 1; writes = 1;
      end
      ok = e_ack[0] && !e_exc && (sb.instr_class_i[0] == 3'd0);
      for (int k = 1; k < N; k++) begin
        clash = 0;
        for (int j = 0; j < k; j++)
          if (e_we[j] && sb.instr_rd_i[j] == sb.instr_rd_i[k] && sb.instr_rd_i[k] != 5'd0) clash = 1;
        if (!sb.instr_valid_i[k] || sb.instr_class_i[k] != 3'd0 || sb.instr_ex_valid_i[k]) ok = 0;
        if (sb.instr_we_i[k] && writes >= WB) ok = 0;
        if (clash) ok = 0;
        if (ok) begin
          e_ack[k] = 1;
          if (sb.instr_we_i[k] && sb.instr_rd_i[k] != 5'd0) begin e_we[k] = 1; writes++; end
        end
      end
    end
`ifdef COMMIT_UNIT_PERF_EN
    e_instret = rst ? 64'd0 : m_instret;
`else
    e_instret = 64'd0;
`endif
  endtask

  task automatic model_update();
    if (rst) begin
      m_drain = 0; m_flush = 0; m_instret = 64'd0;
    end else begin
      m_instret = m_instret + 64'($countones(e_ack)) - 64'(e_exc);
      if (m_flush) m_flush = 0;
      else if (flush) m_drain = 0;
      else if (e_fence) begin m_drain = 0; m_flush = 1; end
      else if (!halt && head_is_fence()) m_drain = 1;
    end
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    model_eval();
    cmp({tag, " ack"}, 64'(sb.commit_ack_o), 64'(e_ack));
    cmp({tag, " cnt"}, 64'(cnt_o), 64'($countones(e_ack)));
    cmp({tag, " we"}, 64'(we_gpr_o), 64'(e_we));
    cmp({tag, " lsu"}, 64'(commit_lsu_o), 64'(e_lsu));
    cmp({tag, " csr"}, 64'(commit_csr_o), 64'(e_csr));
    cmp({tag, " fence"}, 64'(fence_o), 64'(e_fence));
    cmp({tag, " exc"}, 64'(exc_o), 64'(e_exc));
    cmp({tag, " cause"}, cause_o, e_cause);
    cmp({tag, " pc"}, pc_o, e_pc);
    cmp({tag, " instret"}, instret_o, e_instret);
    cmp({tag, " waddr"}, 64'(waddr_o), rst ? 64'd0 : 64'(sb.instr_rd_i));
    cmp({tag, " wdata0"}, wdata_o[0], rst ? 64'd0 : sb.instr_result_i[0]);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    rst = 1; halt = 0; flush = 0; lsu_rdy = 1; no_st = 1;
    m_drain = 0; m_flush = 0; m_instret = 64'd0;
    set_in(4'hF, 12'h000, 4'h0, {5'd4, 5'd3, 5'd2, 5'd1}, 4'hF);

    // Reset: everything quiet even with committable entries at the head.
    check_model("reset");
    cmp("reset ack", 64'(sb.commit_ack_o), 64'd0);
    cmp("reset instret", instret_o, 64'd0);
    advance();
    rst = 0;

    //            valid  cls      ex     rd                               we     lsu nst hlt ack    we
    vecs[0]  = '{4'h3, 12'h000, 4'h0, {5'd0, 5'd0, 5'd6, 5'd5},  4'h3, 1, 1, 0, 4'h3, 4'h3};
    vecs[1]  = '{4'hF, 12'h000, 4'h0, {5'd4, 5'd3, 5'd2, 5'd1},  4'hF, 1, 1, 0, 4'h3, 4'h3};
    vecs[2]  = '{4'hF, 12'h000, 4'h0, {5'd4, 5'd3, 5'd2, 5'd1},  4'h9, 1, 1, 0, 4'hF, 4'h9};
    vecs[3]  = '{4'h3, 12'h000, 4'h0, {5'd0, 5'd0, 5'd7, 5'd7},  4'h3, 1, 1, 0, 4'h1, 4'h1};
    vecs[4]  = '{4'h3, 12'h000, 4'h1, {5'd0, 5'd0, 5'd2, 5'd1},  4'h3, 1, 1, 0, 4'h1, 4'h0};
    vecs[5]  = '{4'h3, 12'h001, 4'h0, {5'd0, 5'd0, 5'd2, 5'd1},  4'h2, 0, 1, 0, 4'h0, 4'h0};
    vecs[6]  = '{4'h3, 12'h001, 4'h0, {5'd0, 5'd0, 5'd2, 5'd1},  4'h2, 1, 1, 0, 4'h1, 4'h0};
    vecs[7]  = '{4'h3, 12'h002, 4'h0, {5'd0, 5'd0, 5'd2, 5'd1},  4'h1, 1, 1, 0, 4'h1, 4'h1};
    vecs[8]  = '{4'h3, 12'h004, 4'h0, {5'd0, 5'd0, 5'd2, 5'd3},  4'h1, 1, 0, 0, 4'h0, 4'h0};
    vecs[9]  = '{4'h3, 12'h004, 4'h0, {5'd0, 5'd0, 5'd2, 5'd3},  4'h1, 1, 1, 0, 4'h1, 4'h1};
    vecs[10] = '{4'hF, 12'h000, 4'h0, {5'd4, 5'd3, 5'd2, 5'd1},  4'hF, 1, 1, 1, 4'h0, 4'h0};
    vecs[11] = '{4'h3, 12'h000, 4'h0, {5'd0, 5'd0, 5'd0, 5'd0},  4'h3, 1, 1, 0, 4'h3, 4'h0};
    vecs[12] = '{4'hD, 12'h000, 4'h0, {5'd4, 5'd3, 5'd2, 5'd1},  4'hF, 1, 1, 0, 4'h1, 4'h1};
    vecs[13] = '{4'hF, 12'h040, 4'h0, {5'd4, 5'd3, 5'd2, 5'd1},  4'h0, 1, 1, 0, 4'h3, 4'h0};
    vecs[14] = '{4'hF, 12'h000, 4'h2, {5'd4, 5'd3, 5'd2, 5'd1},  4'h0, 1, 1, 0, 4'h1, 4'h0};
    vecs[15] = '{4'h7, 12'h000, 4'h0, {5'd0, 5'd9, 5'd10, 5'd9}, 4'h5, 1, 1, 0, 4'h3, 4'h1};
    vecs[16] = '{4'hF, 12'h000, 4'h0, {5'd3, 5'd2, 5'd1, 5'd0},  4'hF, 1, 1, 0, 4'h7, 4'h6};

    foreach (vecs[i]) begin
      set_in(vecs[i].valid, vecs[i].cls, vecs[i].ex, vecs[i].rd, vecs[i].we);
      lsu_rdy = vecs[i].lsu_rdy; no_st = vecs[i].no_st; halt = vecs[i].halt;
      check_model($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d tbl_ack", i), 64'(sb.commit_ack_o), 64'(vecs[i].exp_ack));
      cmp($sformatf("vec%0d tbl_we", i), 64'(we_gpr_o), 64'(vecs[i].exp_we));
      advance();
    end
    halt = 0; lsu_rdy = 1; no_st = 1;

    // Store held at head until the LSU accepts it; the ALU behind never slips past.
    set_in(4'h3, 12'h001, 4'h0, {5'd0, 5'd0, 5'd8, 5'd0}, 4'h2);
    lsu_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      check_model("st_wait");
      cmp("st_wait lsu", 64'(commit_lsu_o), 64'd1);
      cmp("st_wait ack", 64'(sb.commit_ack_o), 64'd0);
      advance();
    end
    lsu_rdy = 1;
    check_model("st_go");
    cmp("st_go lsu", 64'(commit_lsu_o), 64'd1);
    cmp("st_go ack", 64'(sb.commit_ack_o), 64'd1);
    advance();

    // Fence waits in DRAIN for the store buffer, retires with fence_o, then one dead cycle.
    set_in(4'h3, 12'h003, 4'h0, {5'd0, 5'd0, 5'd5, 5'd0}, 4'h2);
    no_st = 0;
    for (int c = 0; c < 2; c++) begin
      check_model("fn_drain");
      cmp("fn_drain ack", 64'(sb.commit_ack_o), 64'd0);
      advance();
    end
    no_st = 1;
    check_model("fn_go");
    cmp("fn_go ack", 64'(sb.commit_ack_o), 64'd1);
    cmp("fn_go fence", 64'(fence_o), 64'd1);
    advance();
    set_in(4'h3, 12'h000, 4'h0, {5'd0, 5'd0, 5'd6, 5'd5}, 4'h3);
    check_model("fn_flush");
    cmp("fn_flush ack", 64'(sb.commit_ack_o), 64'd0);
    advance();
    check_model("fn_idle");
    cmp("fn_idle ack", 64'(sb.commit_ack_o), 64'h3);
    advance();

    // Port-0 exception.
    set_in(4'h3, 12'h000, 4'h1, {5'd0, 5'd0, 5'd2, 5'd1}, 4'h3);
    sb.instr_ex_cause_i[0] = 64'h2;
    sb.instr_pc_i[0] = 64'h8000_0010;
    check_model("exc");
    cmp("exc valid", 64'(exc_o), 64'd1);
    cmp("exc cause", cause_o, 64'h2);
    cmp("exc pc", pc_o, 64'h8000_0010);
    cmp("exc ack", 64'(sb.commit_ack_o), 64'h1);
    cmp("exc we", 64'(we_gpr_o), 64'h0);
    advance();
    set_in(4'h0, 12'h000, 4'h0, 20'd0, 4'h0);
    check_model("exc_after");
    advance();

    // Flush beats a coincident fence retire in DRAIN; fence then retires from IDLE.
    set_in(4'h1, 12'h003, 4'h0, 20'd0, 4'h0);
    no_st = 0;
    check_model("fl_enter");
    advance();
    no_st = 1; flush = 1;
    check_model("fl_both");
    cmp("fl_both ack", 64'(sb.commit_ack_o), 64'd0);
    cmp("fl_both fence", 64'(fence_o), 64'd0);
    advance();
    flush = 0;
    check_model("fl_idle");
    cmp("fl_idle fence", 64'(fence_o), 64'd1);
    advance();
    check_model("fl_flush");
    advance();

    // Reset during DRAIN returns to IDLE and clears instret.
    no_st = 0;
    check_model("rd_enter");
    advance();
    rst = 1;
    check_model("rd_rst");
    cmp("rd_rst ack", 64'(sb.commit_ack_o), 64'd0);
    advance();
    rst = 0; no_st = 1;
    set_in(4'h3, 12'h000, 4'h0, {5'd0, 5'd0, 5'd7, 5'd7}, 4'h3);
    check_model("rd_after");
    cmp("rd_after ack", 64'(sb.commit_ack_o), 64'h1);
    cmp("rd_after instret", instret_o, 64'd0);
    advance();

    // Randomized run against the reference model.
    for (int c = 0; c < 2000; c++) begin
      logic [11:0] cls;
      logic [19:0] rd;
      logic [3:0]  ex;
      for (int k = 0; k < N; k++) begin
        cls[k*3 +: 3] = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, 4));
        rd[k*5 +: 5]  = 5'($urandom_range(0, 7));
        ex[k]         = ($urandom_range(0, 15) == 0);
      end
      set_in(4'($urandom), cls, ex, rd, 4'($urandom));
      lsu_rdy = 1'($urandom);
      no_st   = 1'($urandom);
      halt    = ($urandom_range(0, 9) == 0);
      flush   = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      check_model("rnd");
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/commit_unit_nport.md
Name: commit_unit_nport

Overview:
- Parametrised successor of the core's in-order commit logic.
- Retires up to NR_COMMIT_PORTS instructions per cycle from the scoreboard head, in program order.
- Limits GPR writes per cycle to NR_WB_PORTS.
- Serialises stores, CSR ops and fences through port 0; a fence FSM drains pending stores before committing.
- Sits between the scoreboard and the register file, LSU and CSR file.

Parameters:
- NR_COMMIT_PORTS, 2, instructions inspected/retired per cycle (1..8).
- NR_WB_PORTS, 2, max GPR writes per cycle (1..NR_COMMIT_PORTS).
- XLEN, 64, data width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- halt_i  in  1  block all commits.
- flush_i  in  1  abort fence sequence; FSM to IDLE.
- instr_valid_i  in  [N]  head entry k valid.
- instr_class_i  in  [N][3]  commit_class_e.
- instr_ex_valid_i  in  [N]  entry carries exception.
- instr_ex_cause_i  in  [N][XLEN]  exception cause.
- instr_pc_i  in  [N][XLEN]  entry PC.
- instr_rd_i  in  [N][5]  destination register.
- instr_we_i  in  [N]  entry writes GPR.
- instr_result_i  in  [N][XLEN]  result data.
- lsu_ready_i  in  1  LSU commit buffer ready.
- no_st_pending_i  in  1  store buffer empty.
- commit_ack_o  out  [N]  entry k retired this cycle.
- commit_cnt_o  out  $clog2(N+1)  number retired this cycle.
- we_gpr_o  out  [N]  RF write enable.
- waddr_o  out  [N][5]  RF write address.
- wdata_o  out  [N][XLEN]  RF write data.
- commit_lsu_o  out  1  commit head store.
- commit_csr_o  out  1  commit head CSR op.
- fence_o  out  1  one-cycle fence pulse.
- exception_valid_o  out  1  exception taken.
- exception_cause_o  out  XLEN  cause.
- exception_pc_o  out  XLEN  faulting PC.
- instret_o  out  64  retired-instruction count (optional feature).

Behaviour:
- Combinational commit decision; only FSM state and instret are registered. All outputs are 0 while rst_i is asserted.
- Commit is blocked entirely when halt_i=1 or FSM≠IDLE. The exception: in DRAIN, port 0 may retire the fence.
- Port 0 rules:
  - ex_valid: ack=1, no RF write, exception_valid_o=1 with cause and pc; ports ≥1 blocked.
  - ALU: ack.
  - STORE: commit_lsu_o=1, ack only if lsu_ready_i.
  - CSR: commit_csr_o=1, ack.
  - AMO: ack only if no_st_pending_i.
  - FENCE: handled by the FSM.
- Port k≥1 acks only if all of the following hold:
  - instr_valid_i[k] and ports 0..k-1 acked;
  - its class is ALU, no exception, and all lower ports are ALU;
  - GPR writes granted so far < NR_WB_PORTS (only if instr_we_i[k]);
  - no lower acked port writes the same rd≠0.
- Otherwise port k and all higher ports are blocked that cycle.
- we_gpr_o[k] = ack[k] & instr_we_i[k] & (rd≠0) & ~ex_valid. waddr_o and wdata_o pass through.
- Fence FSM:
  - IDLE: FENCE at port 0, not halted. If no_st_pending_i: ack + fence_o, go FLUSH. Else go DRAIN.
  - DRAIN: wait; when no_st_pending_i: ack + fence_o, go FLUSH.
  - FLUSH: one cycle, no commits, go IDLE.
  - flush_i or rst_i from any state go to IDLE with no ack.
  - halt_i in DRAIN holds DRAIN and suppresses the ack.
- instret wraps modulo 2^64. It adds commit_cnt_o each cycle; exception-acked entries are not counted.
- Simultaneous flush_i and fence ack in DRAIN: flush wins, no ack, no fence_o.

Optional Feature:
- Macro COMMIT_UNIT_PERF_EN.
- Defined: the 64-bit instret register is present and instret_o reflects it.
- Undefined: no counter is synthesised; instret_o is tied to 0.

Decomposition:
- commit_pkg holds:
  - commit_class_e {CLS_ALU=0, CLS_STORE=1, CLS_CSR=2, CLS_FENCE=3, CLS_AMO=4};
  - fence_state_e {IDLE, DRAIN, FLUSH}.
- One natural sub-module: commit_port_arbiter, the combinational per-port eligibility chain including the WB-port budget and rd-conflict check.
- The FSM and instret stay in the top level.

Test Plan:
- N=2, WB=2: two valid ALU ops, rd 5/6, data 0xA/0xB → ack=11, we=11, commit_cnt=2, instret +2.
- N=4, WB=2: four ALU ops all writing distinct rd → ack=0011, commit_cnt=2. Next cycle, with the remaining two at head → ack=0011.
- Head STORE, lsu_ready=0 for 3 cycles then 1 → commit_lsu_o held 4 cycles, ack[0] only in cycle 4; ALU at port 1 never acked alongside.
- FENCE at head, no_st_pending=0 for 2 cycles → FSM DRAIN. When it goes to 1: ack[0]=1 and fence_o=1 in that cycle; next cycle FLUSH with ack=0; then IDLE.
- Port 0 exception, cause 0x2, pc 0x8000_0010 → exception_valid_o=1 with cause 0x2, pc 0x8000_0010; ack=01, we=00, instret unchanged.
- rst_i during DRAIN → next cycle FSM IDLE, all outputs 0, instret=0; ports 0/1 same rd=7 → only port 0 acked.
